dmem_arbiter: RTL

- Two-port arbiter that shares the single-port synchronous data memory (1024 x 32, word index = address[11:2], 1-cycle registered read, read data forced to 0 on a write cycle) between requesters.
- Port 0 is the core load/store port; port 1 is the testbench/debug loader port.
- Registers the winning request, drives the memory's write-enable, address and write-data inputs, captures the read data and returns it with a one-cycle ack to the granted port.

---
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter.
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the 1024x32 sync data memory between two ports.
// Ties go to port 0; define DMEM_ARB_RR_EN for round-robin ties.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              any_req;
  logic              take;
  logic              gnt1;
  logic              win_q;
  logic              wr_q;
  logic              resp;
  logic              hit0;
  logic              hit1;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  assign any_req = p0.req | p1.req;
  assign take    = (state == IDLE) & any_req;

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  assign gnt1 = p1.req & (~p0.req | ~last_q);

  // last-grant pointer; reset to 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (take) begin
      last_q <= gnt1;
    end
  end
`else
  assign gnt1 = p1.req & ~p0.req;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state: one access takes IDLE -> ISSUE -> RESP
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // latch the winner onto the memory bus; write strobe only in ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      win_q     <= 1'b0;
      wr_q      <= 1'b0;
    end else if (take) begin
      mem_we    <= gnt1 ? p1.we    : p0.we;
      mem_addr  <= gnt1 ? p1.addr  : p0.addr;
      mem_wdata <= gnt1 ? p1.wdata : p0.wdata;
      win_q     <= gnt1;
      wr_q      <= gnt1 ? p1.we    : p0.we;
    end else if (state == ISSUE) begin
      mem_we    <= 1'b0;
    end
  end

  // keep each port's last returned data until its next ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (hit0) rdata0_q <= rd_val;
      if (hit1) rdata1_q <= rd_val;
    end
  end

  // ack and live read data to the granted port during RESP
  always_comb begin
    resp     = (state == RESP);
    hit0     = resp & ~win_q;
    hit1     = resp & win_q;
    rd_val   = wr_q ? '0 : mem_rdata;
    p0.ack   = hit0;
    p1.ack   = hit1;
    p0.rdata = hit0 ? rd_val : rdata0_q;
    p1.rdata = hit1 ? rd_val : rdata1_q;
    busy     = (state != IDLE);
  end

endmodule
